// File: rtl/fmul_issue_ctrl_if.sv
// Handshake and multiplier bundle for fmul_issue_ctrl: execute-side request/response
// plus the start/done link to the multi-cycle multiplier.
interface fmul_issue_ctrl_if #(
    parameter int unsigned TAG_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_a;
    logic [31:0]       in_b;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [TAG_W-1:0]  out_tag;
    logic [4:0]        out_fflags;

    logic              mul_start;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [31:0]       mul_result;
    logic              mul_done;

    // Controller side
    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready, mul_result, mul_done,
        output in_ready, out_valid, out_result, out_tag, out_fflags, mul_start, mul_a, mul_b
    );

    // Environment side: execute stage, result consumer and multiplier
    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready, mul_result, mul_done,
        input  in_ready, out_valid, out_result, out_tag, out_fflags, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/fmul_issue_ctrl.sv
// FMUL.S issue controller: classifies operands, resolves special cases locally and
// drives the multiplier start/done protocol for normals. Optional watchdog: FMUL_WDT_EN.
module fmul_issue_ctrl #(
    parameter int unsigned TAG_W      = 5,
    parameter int unsigned WDT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    fmul_issue_ctrl_if.slave bus,
    output logic           busy
);
    localparam int unsigned FLAG_W = 5;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;
    localparam logic [FLAG_W-1:0] FL_NV = 5'b10000;
    localparam logic [FLAG_W-1:0] FL_OF = 5'b00100;
    localparam logic [FLAG_W-1:0] FL_UF = 5'b00010;
    localparam logic [FLAG_W-1:0] FL_NX = 5'b00001;

    typedef enum logic [2:0] {IDLE, CHECK, WAIT_MUL, DRAIN, RESP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_result_q, out_result_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic [FLAG_W-1:0] out_fflags_q, out_fflags_d;
    logic              mul_start_q, mul_start_d;
    logic [31:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;

    // Operand classification on the captured operands (subnormals count as zero)
    logic a_exp_ff, b_exp_ff, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic sign, inf_zero;

    assign a_exp_ff = &a_q[30:23];
    assign b_exp_ff = &b_q[30:23];
    assign a_nan    = a_exp_ff & (|a_q[22:0]);
    assign b_nan    = b_exp_ff & (|b_q[22:0]);
    assign a_snan   = a_nan & ~a_q[22];
    assign b_snan   = b_nan & ~b_q[22];
    assign a_inf    = a_exp_ff & ~(|a_q[22:0]);
    assign b_inf    = b_exp_ff & ~(|b_q[22:0]);
    assign a_zero   = ~(|a_q[30:23]);
    assign b_zero   = ~(|b_q[30:23]);
    assign sign     = a_q[31] ^ b_q[31];
    assign inf_zero = (a_inf & b_zero) | (b_inf & a_zero);

`ifdef FMUL_WDT_EN
    localparam int unsigned WDT_W =
        ($clog2(WDT_CYCLES + 1) > 8) ? $clog2(WDT_CYCLES + 1) : 8;
    logic [WDT_W-1:0] wdt_q, wdt_d;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        tag_d        = tag_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_fflags_d = out_fflags_q;
        mul_start_d  = mul_start_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
`ifdef FMUL_WDT_EN
        wdt_d        = wdt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    tag_d   = bus.in_tag;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                out_tag_d = tag_q;
                if (a_nan || b_nan || inf_zero) begin
                    out_result_d = QNAN;
                    out_fflags_d = (a_snan || b_snan || inf_zero) ? FL_NV : '0;
                    out_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (a_inf || b_inf) begin
                    out_result_d = {sign, 8'hFF, 23'd0};
                    out_fflags_d = '0;
                    out_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (a_zero || b_zero) begin
                    out_result_d = {sign, 31'd0};
                    out_fflags_d = '0;
                    out_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    mul_a_d     = a_q;
                    mul_b_d     = b_q;
                    mul_start_d = 1'b1;
`ifdef FMUL_WDT_EN
                    wdt_d       = '0;
`endif
                    state_d     = WAIT_MUL;
                end
            end
            WAIT_MUL: begin
                if (bus.mul_done) begin
                    mul_start_d = 1'b0;
                    state_d     = DRAIN;
                    // Saturated exponents from the multiplier become exact inf/zero
                    if (&bus.mul_result[30:23]) begin
                        out_result_d = {sign, 8'hFF, 23'd0};
                        out_fflags_d = FL_OF | FL_NX;
                    end else if (~(|bus.mul_result[30:23])) begin
                        out_result_d = {sign, 31'd0};
                        out_fflags_d = FL_UF | FL_NX;
                    end else begin
                        out_result_d = {sign, bus.mul_result[30:0]};
                        out_fflags_d = '0;
                    end
                end
`ifdef FMUL_WDT_EN
                else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
                    mul_start_d  = 1'b0;
                    out_result_d = QNAN;
                    out_fflags_d = FL_NV;
                    state_d      = DRAIN;
                end else begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
`endif
            end
            DRAIN: begin
                // Never issue the next start while a stale done is still up
                if (!bus.mul_done) begin
                    out_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_fflags_q <= '0;
            mul_start_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
`ifdef FMUL_WDT_EN
            wdt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tag_q        <= tag_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_fflags_q <= out_fflags_d;
            mul_start_q  <= mul_start_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
`ifdef FMUL_WDT_EN
            wdt_q        <= wdt_d;
`endif
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_fflags = out_fflags_q;
    assign bus.mul_start  = mul_start_q;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Self-checking bench for fmul_issue_ctrl: directed vector table, backpressure and reset
// sequences, and randomized operands against a behavioural FMUL.S reference model.
module tb_fmul_issue_ctrl;
    localparam int unsigned TAG_W = 5;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    always #5 clk = ~clk;

    fmul_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    fmul_issue_ctrl #(.TAG_W(TAG_W), .WDT_CYCLES(64)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Truncating single-precision multiply for normal operands; saturates exponent range
    function automatic logic [31:0] fp_mul_trunc(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int e;
        logic [47:0] ma, mb, p;
        logic [22:0] frac;
        s  = a[31] ^ b[31];
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        p  = ma * mb;
        if (p[47]) begin
            frac = p[46:24];
            e    = e + 1;
        end else begin
            frac = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, 8'(e), frac};
    endfunction

    // Reference: expected response and whether the multiplier must be used
    task automatic ref_fmul(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output logic [4:0] fl, output bit uses);
        bit a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
        logic s;
        logic [31:0] p;
        a_nan  = (a[30:23] == 8'd255) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'd255) && (b[22:0] != 0);
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        a_inf  = (a[30:23] == 8'd255) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'd255) && (b[22:0] == 0);
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        s      = a[31] ^ b[31];
        uses   = 1'b0;
        fl     = 5'h00;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res = 32'h7FC00000;
            if (a_snan || b_snan || (a_inf && b_zero) || (b_inf && a_zero)) fl = 5'h10;
        end else if (a_inf || b_inf) begin
            res = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            res = {s, 31'd0};
        end else begin
            uses = 1'b1;
            p    = fp_mul_trunc(a, b);
            res  = {s, p[30:0]};
            if (p[30:23] == 8'hFF) fl = 5'h05;
            else if (p[30:23] == 8'h00) fl = 5'h03;
        end
    endtask

    // Multiplier model: answers 5 cycles after start, holds done until start drops
    bit mul_hang  = 1'b0;
    bit flip_sign = 1'b0;
    int mcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mul_done   <= 1'b0;
            bus.mul_result <= '0;
            mcnt           <= 0;
        end else if (!bus.mul_start) begin
            bus.mul_done <= 1'b0;
            mcnt         <= 0;
        end else if (!bus.mul_done && !mul_hang) begin
            if (mcnt == 4) begin
                bus.mul_done   <= 1'b1;
                bus.mul_result <= fp_mul_trunc(bus.mul_a, bus.mul_b) ^ {flip_sign, 31'd0};
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic [31:0] er,
                          input logic [4:0] ef, input bit em, input int hold);
        int cyc;
        bit used, got, opnd_ok;
        cyc = 0;
        while (!bus.in_ready && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_tag   = TAG_W'($urandom);
        cyc = 1; used = 0; got = 0; opnd_ok = 1;
        while (cyc < 300) begin
            if (bus.mul_start) begin
                used = 1;
                if (bus.mul_a !== a || bus.mul_b !== b) opnd_ok = 0;
            end
            if (bus.out_valid) begin
                got = 1;
                break;
            end
            @(posedge clk); #1; cyc++;
        end
        check($sformatf("%s.out_valid_seen", name), 32'(got), 32'd1);
        if (!got) return;
        check($sformatf("%s.mul_used", name), 32'(used), 32'(em));
        if (em) check($sformatf("%s.mul_operands", name), 32'(opnd_ok), 32'd1);
        else    check($sformatf("%s.latency", name), 32'(cyc), 32'd2);
        check($sformatf("%s.result", name), bus.out_result, er);
        check($sformatf("%s.tag", name), 32'(bus.out_tag), 32'(tag));
        check($sformatf("%s.fflags", name), 32'(bus.out_fflags), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s.hold%0d", name, i),
                  {bus.out_valid, bus.in_ready, bus.out_fflags, 25'd0}, {1'b1, 1'b0, ef, 25'd0});
            check($sformatf("%s.hold_result%0d", name, i), bus.out_result, er);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check($sformatf("%s.release", name), {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  fl;
        bit          uses;
        int          hold;
    } vec_t;

    function automatic logic [31:0] rand_operand();
        logic s;
        logic [7:0] e;
        logic [22:0] m;
        s = 1'($urandom);
        m = 23'($urandom);
        case ($urandom_range(0, 11))
            0:       return {s, 31'd0};
            1:       return {s, 8'd0, m | 23'd1};
            2:       return {s, 8'hFF, 23'd0};
            3:       return {s, 8'hFF, 1'b1, m[21:0]};
            4:       return {s, 8'hFF, 1'b0, m[21:0] | 22'd1};
            default: begin
                e = 8'($urandom_range(1, 254));
                return {s, e, m};
            end
        endcase
    endfunction

    vec_t vecs[11];

    initial begin
        logic [31:0] ra, rb, rres;
        logic [4:0]  rfl;
        bit          ruses;
        int          cyc;

        vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 5'h00, 1'b1, 0};
        vecs[1]  = '{32'h3F800000, 32'h40000000, 32'h40000000, 5'h00, 1'b1, 0};
        vecs[2]  = '{32'h80000000, 32'h40A00000, 32'h80000000, 5'h00, 1'b0, 0};
        vecs[3]  = '{32'h00400000, 32'h3F800000, 32'h00000000, 5'h00, 1'b0, 0};
        vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 5'h10, 1'b0, 0};
        vecs[5]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10, 1'b0, 0};
        vecs[6]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'h00, 1'b0, 2};
        vecs[7]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 5'h05, 1'b1, 10};
        vecs[8]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 5'h00, 1'b0, 0};
        vecs[9]  = '{32'h80800000, 32'h00800000, 32'h80000000, 5'h03, 1'b1, 0};
        vecs[10] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 5'h00, 1'b1, 0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        #1;
        check("reset.in_ready_busy", {30'd0, bus.in_ready, busy}, 32'd2);
        check("reset.out_valid_start", {30'd0, bus.out_valid, bus.mul_start}, 32'd0);
        check("reset.out_result", bus.out_result, 32'd0);
        check("reset.tag_flags", {bus.out_tag, bus.out_fflags}, '0);
        check("reset.mul_a", bus.mul_a, 32'd0);
        check("reset.mul_b", bus.mul_b, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, TAG_W'(i + 3),
                   vecs[i].res, vecs[i].fl, vecs[i].uses, vecs[i].hold);

        // Reset while waiting on the multiplier
        mul_hang     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h40000000;
        bus.in_b     = 32'h40400000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.mul_start && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check("rst_mid.start_seen", 32'(bus.mul_start), 32'd1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid.async", {29'd0, bus.mul_start, bus.in_ready, busy}, 32'd2);
        @(posedge clk); #1;
        rst      = 1'b0;
        mul_hang = 1'b0;
        @(posedge clk); #1;

`ifdef FMUL_WDT_EN
        mul_hang = 1'b1;
        run_op("wdt", 32'h40000000, 32'h40400000, TAG_W'(21), 32'h7FC00000, 5'h10, 1'b1, 0);
        mul_hang = 1'b0;
`endif

        for (int i = 0; i < 150; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            ref_fmul(ra, rb, rres, rfl, ruses);
            flip_sign = 1'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb, TAG_W'($urandom), rres, rfl, ruses,
                   $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
